feedback_shift_osc: RTL and testbench
=====================================

# feedback_shift_osc

- Parametrised feedback shift-register oscillator: a WIDTH-stage register whose next state is fed back from its own outputs.
- Run-time modes: ring (one-hot rotate), Johnson (twisted ring) or Fibonacci LFSR; shift direction is selectable.
- Also provides parallel load, self-correction of illegal states, and one-cycle wrap/error flags.
- Next generation of the two-flop reset-seeded oscillator; used as a phase/sequence generator feeding counters and test-pattern logic.

## Interface
- WIDTH, 4: number of stages, 2..32.
- TAPS, 4'b1100: WIDTH-bit LFSR tap mask; must give a maximal-length sequence (default: period 15).
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  advance state on this edge.
- mode  in  2  00 ring, 01 Johnson, 10 LFSR, 11 hold.
- dir  in  1  0: shift toward MSB, 1: shift toward LSB. Ignored in LFSR mode.
- load  in  1  parallel load request.
- load_value  in  WIDTH  value to load.
- q  out  WIDTH  register state.
- wrap  out  1  registered pulse: the shift just returned q to SEED.
- err  out  1  registered pulse: illegal state replaced by SEED.

## Operation
- SEED = WIDTH'b0…01. While reset is high: q = SEED, wrap = 0, err = 0. SEED is legal in every mode.
- Per-edge priority: load > correction > shift > hold.
- Load:
  - When load = 1: q <= load_value, regardless of enable and mode.
  - wrap <= 0, err <= 0.
  - No legality check on the loaded value.
- Legality of q, by mode:
  - Ring: exactly one bit set.
  - Johnson: q is monotone, i.e. ≤1 differing adjacent pair across the WIDTH-1 linear pairs (2·WIDTH legal states).
  - LFSR: q ≠ 0.
  - Hold: always legal.
- Correction: when enable = 1, load = 0, mode ≠ 11 and q is illegal for the current mode: q <= SEED, err <= 1, wrap <= 0.
- Shift: when enable = 1, load = 0, mode ≠ 11 and q is legal:
  - dir 0: q <= {q[W-2:0], fb}. Ring fb = q[W-1]; Johnson fb = ~q[W-1].
  - dir 1: q <= {fb, q[W-1:1]}. Ring fb = q[0]; Johnson fb = ~q[0].
  - LFSR: always dir-0 form, fb = ^(q & TAPS).
  - wrap <= (next q == SEED); err <= 0.
- Otherwise (enable = 0, or mode 11, with no load): q holds; wrap <= 0, err <= 0.
- Mode or dir change: takes effect at the next edge. If q is illegal under the new mode, that edge performs correction, not a shift.
- Periods from SEED, either dir: ring WIDTH, Johnson 2·WIDTH, LFSR 2^WIDTH−1.

## Timing
- Single-cycle latency: every control sampled at edge k is reflected in q, wrap and err after edge k.
- wrap and err are coincident with the q value they describe. Each is high for exactly one cycle per event and never both high together.
- Reset asserted mid-sequence clears q, wrap and err immediately, without waiting for a clock edge.
- After reset release, the first enabled edge shifts from SEED.
- load and enable both high on the same edge: load wins; no shift, no correction.
- load of an illegal value followed by an enabled edge: correction on that edge, err = 1.
- WIDTH = 2 in ring mode behaves as the original two-flop oscillator: 01 → 10 → 01.

## Structure
- Shared package fso_pkg holds:
  - mode encoding constants (MODE_RING, MODE_JOHNSON, MODE_LFSR, MODE_HOLD);
  - a SEED function of WIDTH.
- Sub-module fso_legal_check(WIDTH): purely combinational legality checker; inputs q and mode, output legal.
- The top contains the state register, the feedback mux and the wrap/err flags.

## Test plan
- Reset then ring, WIDTH 4, enable held: q = 0001 → 0010 → 0100 → 1000 → 0001. wrap high only with the second 0001. Repeat with dir 1: 0001 → 1000 → 0100 → 0010 → 0001.
- Johnson, dir 0: 0001 → 0011 → 0111 → 1111 → 1110 → 1100 → 1000 → 0000 → 0001. wrap on the 9th state.
- LFSR with default TAPS: 15 distinct non-zero states, then 0001 with wrap. q never equals 0000.
- Load 0101 in ring mode, then enable: err = 1 and q = 0001 on that edge; next edge gives 0010 with err = 0. Load 0000 in LFSR mode: same correction.
- load and enable on the same edge with load_value 0100: q = 0100, no shift. Mode 11 for 3 edges: q is frozen and the flags stay low.
- Assert reset asynchronously between edges while q = 1000: q = 0001 immediately and flags clear. After release, the sequence restarts from SEED.

Source files
------------

// File: rtl/fso_pkg.sv
// Shared definitions for the feedback shift-register oscillator:
// run-time mode encoding and the reset/correction seed.
package fso_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_HOLD    = 2'b11
    } fso_mode_e;

    localparam int unsigned FSO_MAX_WIDTH = 32;

    // Seed is a single 1 in the LSB; legal in ring, Johnson and LFSR modes.
    function automatic logic [FSO_MAX_WIDTH-1:0] fso_seed(input int unsigned width);
        logic [FSO_MAX_WIDTH-1:0] s;
        s = '0;
        if (width != 0) s[0] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/fso_legal_check.sv
// Combinational legality check of the oscillator state for the current mode.
module fso_legal_check
    import fso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    output logic             legal
);

    fso_mode_e  mode_s;
    logic [5:0] ones_cnt;
    logic [5:0] edge_cnt;

    assign mode_s = fso_mode_e'(mode);

    // edge_cnt counts differing adjacent pairs; a Johnson state has at most one.
    always_comb begin
        ones_cnt = '0;
        edge_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + 6'(q[i]);
        end
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            edge_cnt = edge_cnt + 6'(q[i] ^ q[i+1]);
        end
    end

    always_comb begin
        legal = 1'b1;
        case (mode_s)
            MODE_RING:    legal = (ones_cnt == 6'd1);
            MODE_JOHNSON: legal = (edge_cnt <= 6'd1);
            MODE_LFSR:    legal = (q != '0);
            default:      legal = 1'b1;
        endcase
    end

endmodule

// File: rtl/feedback_shift_osc.sv
// Feedback shift-register oscillator: ring / Johnson / LFSR with parallel load,
// self-correction of illegal states and one-cycle wrap/err flags.
module feedback_shift_osc
    import fso_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(fso_seed(WIDTH));

    fso_mode_e        mode_s;
    logic             legal;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    assign mode_s = fso_mode_e'(mode);

    fso_legal_check #(
        .WIDTH (WIDTH)
    ) u_legal (
        .q     (q_q),
        .mode  (mode),
        .legal (legal)
    );

    // LFSR ignores dir and always shifts toward the MSB.
    always_comb begin
        shifted = q_q;
        case (mode_s)
            MODE_RING:
                shifted = dir ? {q_q[0], q_q[WIDTH-1:1]}
                              : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_JOHNSON:
                shifted = dir ? {~q_q[0], q_q[WIDTH-1:1]}
                              : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            MODE_LFSR:
                shifted = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
            default:
                shifted = q_q;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            q_d = load_value;
        end else if (enable && (mode_s != MODE_HOLD)) begin
            if (!legal) begin
                q_d   = SEED;
                err_d = 1'b1;
            end else begin
                q_d    = shifted;
                wrap_d = (shifted == SEED);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= SEED;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_feedback_shift_osc.sv
// Self-checking bench for feedback_shift_osc (WIDTH 4, default taps):
// directed sequences plus randomized traffic against a behavioural model.
module tb_feedback_shift_osc;

    localparam int W    = 4;
    localparam int SPAN = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = SPAN - 1;
    localparam int TAPS_I = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] q;
    logic         wrap;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_q, m_wrap, m_err;

    logic [3:0] RING_UP   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] RING_DOWN [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] JOHN_UP   [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                  4'b1100, 4'b1000, 4'b0000, 4'b0001};

    feedback_shift_osc #(
        .WIDTH (W),
        .TAPS  (4'b1100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .q          (q),
        .wrap       (wrap),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Legal-state sets straight from the rules: one-hot, monotone, non-zero.
    function automatic bit is_legal(int v, int md);
        bit ok;
        ok = 1'b0;
        case (md)
            0: ok = ($countones(v) == 1);
            1: for (int k = 0; k <= W; k++)
                   if (v == (1 << k) - 1 || v == FULL - ((1 << k) - 1)) ok = 1'b1;
            2: ok = (v != 0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic int shift_of(int v, int md, bit d);
        int top, bot;
        top = v / HALF;
        bot = v % 2;
        case (md)
            0: return d ? (v / 2 + bot * HALF) : ((v * 2) % SPAN + top);
            1: return d ? (v / 2 + (1 - bot) * HALF) : ((v * 2) % SPAN + (1 - top));
            2: return (v * 2) % SPAN + ($countones(v & TAPS_I) % 2);
            default: return v;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load = 1'b0;
        enable = 1'b0;
        step();
        reset = 1'b0;
        m_q = 1; m_wrap = 0; m_err = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (q !== 4'b0001) begin n_bad++; $display("FAIL reset_q: got %b expected 0001", q); end
        n_cmp++;
        if (wrap !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got wrap=%b err=%b expected 0 0", wrap, err);
        end
        reset = 1'b0;
    endtask

    task automatic test_ring();
        do_reset();
        mode = 2'b00; dir = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (q !== RING_UP[i] || wrap !== (i == 3) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL ring_up[%0d]: got q=%b wrap=%b err=%b expected q=%b wrap=%b err=0",
                         i, q, wrap, err, RING_UP[i], (i == 3));
            end
        end
        dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (q !== RING_DOWN[i] || wrap !== (i == 3) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL ring_down[%0d]: got q=%b wrap=%b err=%b expected q=%b wrap=%b err=0",
                         i, q, wrap, err, RING_DOWN[i], (i == 3));
            end
        end
    endtask

    task automatic test_johnson();
        do_reset();
        mode = 2'b01; dir = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (q !== JOHN_UP[i] || wrap !== (i == 7) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL johnson[%0d]: got q=%b wrap=%b err=%b expected q=%b wrap=%b err=0",
                         i, q, wrap, err, JOHN_UP[i], (i == 7));
            end
        end
    endtask

    task automatic test_lfsr();
        bit [SPAN-1:0] seen;
        seen = '0;
        do_reset();
        mode = 2'b10; dir = 1'b1; enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_cmp++;
            if (q === 4'b0000 || seen[q] || wrap !== (i == 14) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL lfsr[%0d]: got q=%b repeat=%b wrap=%b err=%b expected new nonzero q wrap=%b err=0",
                         i, q, seen[q], wrap, err, (i == 14));
            end
            seen[q] = 1'b1;
        end
        n_cmp++;
        if (q !== 4'b0001) begin n_bad++; $display("FAIL lfsr_period: got %b expected 0001", q); end
    endtask

    task automatic test_correction();
        do_reset();
        mode = 2'b00; dir = 1'b0;
        load = 1'b1; load_value = 4'b0101; enable = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'b0101 || err !== 1'b0) begin
            n_bad++; $display("FAIL load_illegal: got q=%b err=%b expected 0101 0", q, err);
        end
        load = 1'b0; enable = 1'b1;
        step();
        n_cmp++;
        if (q !== 4'b0001 || err !== 1'b1 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL ring_correct: got q=%b err=%b wrap=%b expected 0001 1 0", q, err, wrap);
        end
        step();
        n_cmp++;
        if (q !== 4'b0010 || err !== 1'b0) begin
            n_bad++; $display("FAIL after_correct: got q=%b err=%b expected 0010 0", q, err);
        end
        mode = 2'b10; load = 1'b1; load_value = 4'b0000;
        step();
        load = 1'b0;
        step();
        n_cmp++;
        if (q !== 4'b0001 || err !== 1'b1 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL lfsr_correct: got q=%b err=%b wrap=%b expected 0001 1 0", q, err, wrap);
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        mode = 2'b00; dir = 1'b0; enable = 1'b1;
        load = 1'b1; load_value = 4'b0100;
        step();
        n_cmp++;
        if (q !== 4'b0100 || wrap !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL load_wins: got q=%b wrap=%b err=%b expected 0100 0 0", q, wrap, err);
        end
        load = 1'b0; mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (q !== 4'b0100 || wrap !== 1'b0 || err !== 1'b0) begin
                n_bad++; $display("FAIL hold[%0d]: got q=%b wrap=%b err=%b expected 0100 0 0", i, q, wrap, err);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 2'b00; dir = 1'b0; enable = 1'b1;
        step(); step(); step();
        enable = 1'b0;
        n_cmp++;
        if (q !== 4'b1000) begin n_bad++; $display("FAIL pre_reset: got %b expected 1000", q); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: got q=%b wrap=%b err=%b expected 0001 0 0", q, wrap, err);
        end
        reset = 1'b0;
        load = 1'b1; load_value = 4'b0110;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (err !== 1'b0 || q !== 4'b0001) begin
            n_bad++; $display("FAIL async_err_clear: got q=%b err=%b expected 0001 0", q, err);
        end
        #2 reset = 1'b0;
        enable = 1'b1;
        step();
        n_cmp++;
        if (q !== 4'b0010 || err !== 1'b0 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL restart: got q=%b err=%b wrap=%b expected 0010 0 0", q, err, wrap);
        end
    endtask

    task automatic test_random();
        int nq, nw, ne;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            load_value = 4'($urandom_range(0, FULL));
            enable     = ($urandom_range(0, 3) != 0);
            mode       = 2'($urandom_range(0, 3));
            dir        = 1'($urandom_range(0, 1));
            nq = m_q; nw = 0; ne = 0;
            if (load) begin
                nq = int'(load_value);
            end else if (enable && mode != 2'b11) begin
                if (!is_legal(m_q, int'(mode))) begin
                    nq = 1; ne = 1;
                end else begin
                    nq = shift_of(m_q, int'(mode), dir);
                    nw = (nq == 1);
                end
            end
            m_q = nq; m_wrap = nw; m_err = ne;
            step();
            n_cmp++;
            if (q !== 4'(m_q) || wrap !== 1'(m_wrap) || err !== 1'(m_err)) begin
                n_bad++;
                $display("FAIL random[%0d]: got q=%b wrap=%b err=%b expected q=%b wrap=%0d err=%0d",
                         i, q, wrap, err, 4'(m_q), m_wrap, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'b00; dir = 1'b0;
        load = 1'b0; load_value = '0;
        test_reset();
        test_ring();
        test_johnson();
        test_lfsr();
        test_correction();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
